// File: rtl/xmem_dp.sv
// xmem_dp: dual-port memory functional unit for the Versat datapath.
// Port A is driven by a two-level address generator (flow side), port B is
// a pipelined host/DMA port. Both ports access the RAM concurrently.
// RAM contents are not initialised; load them through the host port.
// Optional feature: define XMEM_DP_RVRS_EN to add cfg_rvrs_i, which
// bit-reverses the generated port-A address (FFT ordering).
module xmem_dp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int N_SRC  = 8,
    parameter int PER_W  = 5,
    localparam int SEL_W = $clog2(N_SRC)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    run_i,
    output logic                    done_o,
    input  logic                    h_valid_i,
    input  logic                    h_we_i,
    input  logic [ADDR_W-1:0]       h_addr_i,
    input  logic [DATA_W-1:0]       h_wdata_i,
    output logic [DATA_W-1:0]       h_rdata_o,
    output logic                    h_ready_o,
    input  logic [N_SRC*DATA_W-1:0] flow_in_i,
    output logic [DATA_W-1:0]       flow_out_o,
    input  logic [ADDR_W-1:0]       cfg_start_i,
    input  logic [ADDR_W-1:0]       cfg_incr_i,
    input  logic [ADDR_W-1:0]       cfg_shift_i,
    input  logic [ADDR_W-1:0]       cfg_iter_i,
    input  logic [PER_W-1:0]        cfg_per_i,
    input  logic [PER_W-1:0]        cfg_duty_i,
    input  logic [PER_W-1:0]        cfg_delay_i,
    input  logic [SEL_W-1:0]        cfg_sel_i,
    input  logic                    cfg_in_wr_i,
`ifdef XMEM_DP_RVRS_EN
    input  logic                    cfg_rvrs_i,
`endif
    input  logic                    cfg_ext_i
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DELAY  = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]  dly_cnt_q, dly_cnt_d;

    logic [ADDR_W-1:0] incr_q, shift_q, iter_q;
    logic [PER_W-1:0]  per_q, duty_q, delay_q;
    logic [SEL_W-1:0]  sel_q;
    logic              in_wr_q, ext_q;

    logic [PER_W-1:0]  per_eff, duty_eff;
    logic              en_a, per_end, run_go;
    logic [DATA_W-1:0] flow_sel;
    logic [ADDR_W-1:0] gen_addr;

    logic              a_vld_p1_q, a_we_p1_q, h_vld_p1_q, h_we_p1_q;
    logic [ADDR_W-1:0] a_addr_p1_q, h_addr_p1_q;
    logic [DATA_W-1:0] a_wdata_p1_q, h_wdata_p1_q;
    logic [DATA_W-1:0] flow_out_q, h_rdata_q;
    logic              h_ready_q;
    logic [DATA_W-1:0] mem [DEPTH];

    // A zero period behaves as a one-cycle period; duty never exceeds it.
    assign per_eff  = (per_q == '0) ? PER_W'(1) : per_q;
    assign duty_eff = (duty_q < per_eff) ? duty_q : per_eff;
    assign en_a     = (state_q == S_ACTIVE) && (iter_q != '0) && (per_cnt_q < duty_eff);
    assign per_end  = (per_cnt_q == per_eff - PER_W'(1));
    assign run_go   = run_i && (state_q == S_IDLE);
    assign flow_sel = flow_in_i[sel_q*DATA_W +: DATA_W];
    assign done_o   = (state_q == S_IDLE);

`ifdef XMEM_DP_RVRS_EN
    logic rvrs_q;

    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] a);
        for (int k = 0; k < ADDR_W; k++) bit_rev[k] = a[ADDR_W-1-k];
    endfunction

    // Capture the reversal mode together with the rest of the configuration.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rvrs_q <= 1'b0;
        else if (run_go) rvrs_q <= cfg_rvrs_i;
    end

    assign gen_addr = rvrs_q ? bit_rev(addr_q) : addr_q;
`else
    assign gen_addr = addr_q;
`endif

    // Generator next state: delay phase, then period/iteration counting.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        iter_cnt_d = iter_cnt_q;
        per_cnt_d  = per_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    addr_d     = cfg_start_i;
                    iter_cnt_d = '0;
                    per_cnt_d  = '0;
                    dly_cnt_d  = '0;
                    // Zero iterations skip the delay so done drops for one cycle only.
                    state_d = ((cfg_delay_i != '0) && (cfg_iter_i != '0)) ? S_DELAY : S_ACTIVE;
                end
            end
            S_DELAY: begin
                if (dly_cnt_q == delay_q - PER_W'(1)) state_d = S_ACTIVE;
                else dly_cnt_d = dly_cnt_q + PER_W'(1);
            end
            S_ACTIVE: begin
                if (iter_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d = addr_q + (en_a ? incr_q : '0) + (per_end ? shift_q : '0);
                    if (per_end) begin
                        per_cnt_d  = '0;
                        iter_cnt_d = iter_cnt_q + ADDR_W'(1);
                        if (iter_cnt_q + ADDR_W'(1) == iter_q) state_d = S_IDLE;
                    end else begin
                        per_cnt_d = per_cnt_q + PER_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Generator state and counters.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            iter_cnt_q <= '0;
            per_cnt_q  <= '0;
            dly_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            iter_cnt_q <= iter_cnt_d;
            per_cnt_q  <= per_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
        end
    end

    // Shadow configuration, frozen for the whole run.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            incr_q  <= '0;
            shift_q <= '0;
            iter_q  <= '0;
            per_q   <= '0;
            duty_q  <= '0;
            delay_q <= '0;
            sel_q   <= '0;
            in_wr_q <= 1'b0;
            ext_q   <= 1'b0;
        end else if (run_go) begin
            incr_q  <= cfg_incr_i;
            shift_q <= cfg_shift_i;
            iter_q  <= cfg_iter_i;
            per_q   <= cfg_per_i;
            duty_q  <= cfg_duty_i;
            delay_q <= cfg_delay_i;
            sel_q   <= cfg_sel_i;
            in_wr_q <= cfg_in_wr_i;
            ext_q   <= cfg_ext_i;
        end
    end

    // Stage p1 control: request strobes, cleared by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_vld_p1_q <= 1'b0;
            a_we_p1_q  <= 1'b0;
            h_vld_p1_q <= 1'b0;
            h_we_p1_q  <= 1'b0;
        end else begin
            a_vld_p1_q <= en_a;
            a_we_p1_q  <= en_a && in_wr_q && !ext_q;
            h_vld_p1_q <= h_valid_i;
            h_we_p1_q  <= h_we_i;
        end
    end

    // Stage p1 data: addresses and write data, no reset needed.
    always_ff @(posedge clk_i) begin
        a_addr_p1_q  <= ext_q ? flow_sel[ADDR_W-1:0] : gen_addr;
        a_wdata_p1_q <= flow_sel;
        h_addr_p1_q  <= h_addr_i;
        h_wdata_p1_q <= h_wdata_i;
    end

    // Stage p2 RAM writes; host write is last so it wins a same-address collision.
    always_ff @(posedge clk_i) begin
        if (a_we_p1_q) mem[a_addr_p1_q] <= a_wdata_p1_q;
        if (h_vld_p1_q && h_we_p1_q) mem[h_addr_p1_q] <= h_wdata_p1_q;
    end

    // Stage p2 registered read-first outputs; flow_out holds when port A is idle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            flow_out_q <= '0;
            h_rdata_q  <= '0;
            h_ready_q  <= 1'b0;
        end else begin
            if (a_vld_p1_q) flow_out_q <= mem[a_addr_p1_q];
            if (h_vld_p1_q && !h_we_p1_q) h_rdata_q <= mem[h_addr_p1_q];
            h_ready_q <= h_vld_p1_q;
        end
    end

    assign flow_out_o = flow_out_q;
    assign h_rdata_o  = h_rdata_q;
    assign h_ready_o  = h_ready_q;

endmodule

// File: tb/tb_xmem_dp.sv
// Testbench for xmem_dp: behavioural reference model (address schedule built
// from nested loops, two-cycle access latency, read-first RAM) compared every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_xmem_dp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int N_SRC  = 8;
    localparam int PER_W  = 5;
    localparam int SEL_W  = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    run = 1'b0;
    logic                    done;
    logic                    h_valid = 1'b0, h_we = 1'b0;
    logic [ADDR_W-1:0]       h_addr = '0;
    logic [DATA_W-1:0]       h_wdata = '0;
    logic [DATA_W-1:0]       h_rdata;
    logic                    h_ready;
    logic [N_SRC*DATA_W-1:0] flow_in = '0;
    logic [DATA_W-1:0]       flow_out;
    logic [ADDR_W-1:0]       c_start = '0, c_incr = '0, c_shift = '0, c_iter = '0;
    logic [PER_W-1:0]        c_per = '0, c_duty = '0, c_delay = '0;
    logic [SEL_W-1:0]        c_sel = '0;
    logic                    c_in_wr = 1'b0, c_ext = 1'b0;
`ifdef XMEM_DP_RVRS_EN
    logic                    c_rvrs = 1'b0;
`endif

    xmem_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_SRC(N_SRC), .PER_W(PER_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .done_o(done),
        .h_valid_i(h_valid), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdata_i(h_wdata),
        .h_rdata_o(h_rdata), .h_ready_o(h_ready),
        .flow_in_i(flow_in), .flow_out_o(flow_out),
        .cfg_start_i(c_start), .cfg_incr_i(c_incr), .cfg_shift_i(c_shift), .cfg_iter_i(c_iter),
        .cfg_per_i(c_per), .cfg_duty_i(c_duty), .cfg_delay_i(c_delay), .cfg_sel_i(c_sel),
        .cfg_in_wr_i(c_in_wr),
`ifdef XMEM_DP_RVRS_EN
        .cfg_rvrs_i(c_rvrs),
`endif
        .cfg_ext_i(c_ext)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] mmem [DEPTH];
    bit                sch_en[$];
    logic [ADDR_W-1:0] sch_addr[$];
    bit                busy = 1'b0;
    int                m_sel = 0;
    bit                m_in_wr = 1'b0, m_ext = 1'b0;
    bit                pa_vld = 1'b0, pa_we = 1'b0, ph_vld = 1'b0, ph_we = 1'b0;
    logic [ADDR_W-1:0] pa_addr = '0, ph_addr = '0;
    logic [DATA_W-1:0] pa_wd = '0, ph_wd = '0;
    logic [DATA_W-1:0] exp_flow = '0, exp_rdata = '0;
    bit                exp_ready = 1'b0;

    // One schedule entry per cycle after run: delay cycles, then iter*period cycles.
    task automatic build_sched();
        int pe, du;
        logic [ADDR_W-1:0] a;
        sch_en.delete();
        sch_addr.delete();
        pe = (c_per == 0) ? 1 : int'(c_per);
        du = (int'(c_duty) < pe) ? int'(c_duty) : pe;
        if (c_iter == 0) begin
            sch_en.push_back(1'b0);
            sch_addr.push_back('0);
        end else begin
            for (int d = 0; d < int'(c_delay); d++) begin
                sch_en.push_back(1'b0);
                sch_addr.push_back('0);
            end
            a = c_start;
            for (int it = 0; it < int'(c_iter); it++) begin
                for (int p = 0; p < pe; p++) begin
                    if (p < du) begin
                        sch_en.push_back(1'b1);
                        sch_addr.push_back(a);
                        a = a + c_incr;
                    end else begin
                        sch_en.push_back(1'b0);
                        sch_addr.push_back('0);
                    end
                end
                a = a + c_shift;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            busy = 1'b0;
            sch_en.delete();
            sch_addr.delete();
            pa_vld = 1'b0; pa_we = 1'b0; ph_vld = 1'b0; ph_we = 1'b0;
            exp_flow = '0; exp_rdata = '0; exp_ready = 1'b0;
        end else begin
            bit was_busy, ca_vld, ca_we;
            logic [ADDR_W-1:0] ca_addr;
            logic [DATA_W-1:0] sel_word;
            sel_word = flow_in[m_sel*DATA_W +: DATA_W];
            was_busy = busy;
            ca_vld = 1'b0; ca_we = 1'b0; ca_addr = '0;
            if (busy) begin
                ca_vld = sch_en.pop_front();
                ca_addr = sch_addr.pop_front();
                if (m_ext) ca_addr = sel_word[ADDR_W-1:0];
                ca_we = ca_vld && m_in_wr && !m_ext;
                if (sch_en.size() == 0) busy = 1'b0;
            end
            // requests from the previous cycle hit the RAM now, read-first
            if (pa_vld) exp_flow = mmem[pa_addr];
            exp_ready = ph_vld;
            if (ph_vld && !ph_we) exp_rdata = mmem[ph_addr];
            if (pa_we) mmem[pa_addr] = pa_wd;
            if (ph_vld && ph_we) mmem[ph_addr] = ph_wd;
            pa_vld = ca_vld; pa_we = ca_we; pa_addr = ca_addr; pa_wd = sel_word;
            ph_vld = h_valid; ph_we = h_we; ph_addr = h_addr; ph_wd = h_wdata;
            if (!was_busy && run) begin
                m_sel = int'(c_sel);
                m_in_wr = c_in_wr;
                m_ext = c_ext;
                build_sched();
                busy = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        check("done", 32'(done), 32'(!busy));
        check("h_ready", 32'(h_ready), 32'(exp_ready));
        check("h_rdata", h_rdata, exp_rdata);
        check("flow_out", flow_out, exp_flow);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic set_cfg(input int st, input int inc, input int sh, input int it, input int pe,
                           input int du, input int dl, input int sl, input bit wr, input bit ex);
        c_start = ADDR_W'(st); c_incr = ADDR_W'(inc); c_shift = ADDR_W'(sh); c_iter = ADDR_W'(it);
        c_per = PER_W'(pe); c_duty = PER_W'(du); c_delay = PER_W'(dl); c_sel = SEL_W'(sl);
        c_in_wr = wr; c_ext = ex;
    endtask

    task automatic host_write(input int a, input logic [DATA_W-1:0] d);
        h_valid = 1'b1; h_we = 1'b1; h_addr = ADDR_W'(a); h_wdata = d;
        tick();
        h_valid = 1'b0; h_we = 1'b0;
    endtask

    task automatic host_read_check(input string nm, input int a, input logic [DATA_W-1:0] exp);
        h_valid = 1'b1; h_we = 1'b0; h_addr = ADDR_W'(a);
        tick();
        h_valid = 1'b0;
        tick();
        @(negedge clk);
        check({nm, "_ready"}, 32'(h_ready), 32'd1);
        check(nm, h_rdata, exp);
        tick();
    endtask

    task automatic rand_flow();
        for (int s = 0; s < N_SRC; s++) flow_in[s*DATA_W +: DATA_W] = $urandom();
    endtask

    int t3_flow[11] = '{4, 6, 6, 6, 4, 6, 6, 6, 4, 6, 6};
    logic [31:0] t4_flow[4] = '{32'hC0DE1020, 32'hC0DE1023, 32'd2, 32'd5};

    initial begin
        // reset state
        tick(); tick();
        @(negedge clk);
        check("rst_done", 32'(done), 32'd1);
        check("rst_flow", flow_out, 32'd0);
        check("rst_rdata", h_rdata, 32'd0);
        check("rst_ready", 32'(h_ready), 32'd0);
        rst_n = 1'b1;
        tick();

        // host write strobes ready too
        host_write(0, 32'd0);
        tick();
        @(negedge clk);
        check("wr_ready", 32'(h_ready), 32'd1);
        tick();

        // host writes i to addr i, read back
        for (int i = 0; i < 16; i++) host_write(i, DATA_W'(i));
        for (int i = 0; i < 16; i++) host_read_check("t1_rd", i, DATA_W'(i));
        for (int a = 16; a < DEPTH; a++) host_write(a, $urandom());
        host_write(1020, 32'hC0DE1020);
        host_write(1023, 32'hC0DE1023);
        tick();

        // linear read of 0..7
        set_cfg(0, 1, 0, 1, 8, 8, 0, 0, 1'b0, 1'b0);
        pulse_run();
        for (int off = 1; off <= 10; off++) begin
            @(negedge clk);
            if (off >= 3) check("t2_flow", flow_out, 32'(off - 3));
            if (off == 8) check("t2_done_lo", 32'(done), 32'd0);
            if (off == 9) check("t2_done_hi", 32'(done), 32'd1);
        end
        tick();

        // strided with shift: 4,6,4,6,4,6 and gaps of 2
        set_cfg(4, 2, -4, 3, 4, 2, 0, 0, 1'b0, 1'b0);
        pulse_run();
        for (int off = 1; off <= 13; off++) begin
            @(negedge clk);
            if (off >= 3) check("t3_flow", flow_out, 32'(t3_flow[off - 3]));
            if (off == 12) check("t3_done_lo", 32'(done), 32'd0);
            if (off == 13) check("t3_done_hi", 32'(done), 32'd1);
        end
        tick();

        // address wrap: 1020,1023,2,5
        set_cfg(1020, 3, 0, 1, 4, 4, 0, 0, 1'b0, 1'b0);
        pulse_run();
        for (int off = 1; off <= 6; off++) begin
            @(negedge clk);
            if (off >= 3) check("t4_flow", flow_out, t4_flow[off - 3]);
        end
        tick();

        // zero iterations: done low for a single cycle, no access
        set_cfg(0, 1, 0, 0, 4, 4, 3, 0, 1'b0, 1'b0);
        pulse_run();
        for (int off = 1; off <= 3; off++) begin
            @(negedge clk);
            if (off == 1) check("it0_done_lo", 32'(done), 32'd0);
            if (off == 2) check("it0_done_hi", 32'(done), 32'd1);
            if (off == 3) check("it0_flow_hold", flow_out, 32'd5);
        end
        tick();

        // collision: port A and host write addr 7 in the same cycle
        flow_in = '0;
        flow_in[31:0] = 32'h0000AAAA;
        set_cfg(7, 0, 0, 1, 1, 1, 0, 0, 1'b1, 1'b0);
        pulse_run();
        h_valid = 1'b1; h_we = 1'b1; h_addr = 10'd7; h_wdata = 32'h00005555;
        tick();
        h_valid = 1'b0; h_we = 1'b0;
        tick(); tick();
        host_read_check("t5_collide", 7, 32'h00005555);

        // reset in the middle of a run, then a full rerun
        set_cfg(0, 1, 0, 5, 4, 4, 2, 0, 1'b0, 1'b0);
        pulse_run();
        for (int off = 1; off <= 4; off++) @(negedge clk);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_done", 32'(done), 32'd1);
        check("t6_rst_flow", flow_out, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        pulse_run();
        for (int off = 1; off <= 23; off++) begin
            @(negedge clk);
            if (off >= 5 && off <= 8) check("t6_flow", flow_out, 32'(off - 5));
            if (off == 22) check("t6_done_lo", 32'(done), 32'd0);
            if (off == 23) check("t6_done_hi", 32'(done), 32'd1);
        end
        tick();

        // randomized runs with concurrent host traffic
        for (int n = 0; n < 60; n++) begin
            int cyc;
            set_cfg(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, N_SRC - 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            rand_flow();
            pulse_run();
            cyc = 0;
            while (!done && cyc < 400) begin
                h_valid = 1'($urandom_range(0, 1));
                h_we = 1'($urandom_range(0, 1));
                h_addr = ADDR_W'($urandom());
                h_wdata = $urandom();
                rand_flow();
                run = ($urandom_range(0, 7) == 0);
                if (n % 7 == 3 && cyc == 5) begin
                    h_valid = 1'b0; run = 1'b0;
                    rst_n = 1'b0;
                    tick();
                    rst_n = 1'b1;
                end
                tick();
                cyc++;
            end
            run = 1'b0; h_valid = 1'b0;
            check("run_timeout", 32'(done), 32'd1);
            tick(); tick(); tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
